ram_port_arbiter: RTL and testbench

- Shares one simple-dual-port block RAM (64 x 32, port A write, port B read) between N requesters, e.g. the prefix-sum transfer engine and a readback/display unit.
- Arbitrates write port A and read port B independently, each with its own round-robin pointer.
- Returns read data to the winning requester with fixed latency.
- Forwards same-cycle write data so results do not depend on the RAM collision mode.

---
 rtl/ram_arb_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/ram_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_ram_port_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared definitions for the block-RAM port arbiter: default RAM geometry
// and the round-robin pointer wrap helper.
package ram_arb_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 32;

  // Pointer value that follows a grant to requester k among n requesters.
  function automatic int rr_next(input int k, input int n);
    int nxt;
    if (k + 1 >= n) begin
      nxt = 0;
    end else begin
      nxt = k + 1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or
// above ptr_i, wrapping past N-1 back to 0. Output is one-hot or zero.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  logic [PW-1:0] idx_s;
  logic          found_s;
  logic          hit_s;

  // Walk the requesters starting at the pointer and keep only the first hit.
  always_comb begin
    gnt_o   = '0;
    found_s = 1'b0;
    hit_s   = 1'b0;
    idx_s   = ptr_i;
    for (int off = 0; off < N; off++) begin
      hit_s        = !found_s && req_i[idx_s];
      gnt_o[idx_s] = gnt_o[idx_s] | hit_s;
      found_s      = found_s | hit_s;
      idx_s        = (int'(idx_s) == N - 1) ? '0 : idx_s + PW'(1);
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one simple-dual-port block RAM between N_REQ requesters. Write
// port A and read port B are arbitrated independently with round-robin
// pointers; read data returns after RD_LAT cycles, and a read that collides
// with a same-cycle write to the same address returns the written data.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        wr_req,
  input  logic [N_REQ*ADDR_W-1:0] wr_addr,
  input  logic [N_REQ*DATA_W-1:0] wr_data,
  output logic [N_REQ-1:0]        wr_gnt,
  input  logic [N_REQ-1:0]        rd_req,
  input  logic [N_REQ*ADDR_W-1:0] rd_addr,
  output logic [N_REQ-1:0]        rd_gnt,
  output logic [N_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]       rd_data,
  output logic [ADDR_W-1:0]       addra,
  output logic [DATA_W-1:0]       din,
  output logic                    wea,
  output logic [ADDR_W-1:0]       addrb,
  input  logic [DATA_W-1:0]       dout
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [N_REQ-1:0]  wr_gnt_raw_s, rd_gnt_raw_s;
  logic [PW-1:0]     wr_idx_s, rd_idx_s;
  logic [ADDR_W-1:0] wr_addr_s, rd_addr_s;
  logic [DATA_W-1:0] wr_data_s;
  logic              wr_any_s, rd_any_s, fwd_s;

  // addra/din/addrb keep their last granted value between grants
  logic [ADDR_W-1:0] addra_q, addra_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [ADDR_W-1:0] addrb_q, addrb_d;

  // Read return pipeline: grant vector, forward tag and captured write data
  logic [N_REQ-1:0]  vld_q  [RD_LAT];
  logic              fwd_q  [RD_LAT];
  logic [DATA_W-1:0] fdat_q [RD_LAT];

  rr_arbiter #(.N(N_REQ), .PW(PW)) u_wr_arb (
    .req_i (wr_req),
    .ptr_i (wr_ptr_q),
    .gnt_o (wr_gnt_raw_s)
  );

  rr_arbiter #(.N(N_REQ), .PW(PW)) u_rd_arb (
    .req_i (rd_req),
    .ptr_i (rd_ptr_q),
    .gnt_o (rd_gnt_raw_s)
  );

  // Mask grants during reset and mux index/address/data from the winners.
  always_comb begin
    wr_gnt    = rst ? '0 : wr_gnt_raw_s;
    rd_gnt    = rst ? '0 : rd_gnt_raw_s;
    wr_idx_s  = '0;
    rd_idx_s  = '0;
    wr_addr_s = '0;
    wr_data_s = '0;
    rd_addr_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      wr_idx_s  |= wr_gnt[i] ? PW'(i) : '0;
      rd_idx_s  |= rd_gnt[i] ? PW'(i) : '0;
      wr_addr_s |= wr_gnt[i] ? wr_addr[i*ADDR_W +: ADDR_W] : '0;
      wr_data_s |= wr_gnt[i] ? wr_data[i*DATA_W +: DATA_W] : '0;
      rd_addr_s |= rd_gnt[i] ? rd_addr[i*ADDR_W +: ADDR_W] : '0;
    end
    wr_any_s = |wr_gnt;
    rd_any_s = |rd_gnt;
    fwd_s    = wr_any_s && rd_any_s && (wr_addr_s == rd_addr_s);
  end

  // Next-state for pointers and held RAM port values, plus the RAM port drive.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    addra_d  = addra_q;
    din_d    = din_q;
    addrb_d  = addrb_q;
    if (wr_any_s) begin
      wr_ptr_d = PW'(rr_next(int'(wr_idx_s), N_REQ));
      addra_d  = wr_addr_s;
      din_d    = wr_data_s;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_any_s) begin
      rd_ptr_d = PW'(rr_next(int'(rd_idx_s), N_REQ));
      addrb_d  = rd_addr_s;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    wea = wr_any_s;
    if (rst) begin
      addra = '0;
      din   = '0;
      addrb = '0;
    end else begin
      addra = addra_d;
      din   = din_d;
      addrb = addrb_d;
    end
  end

  // Pointer, held-port and read-pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      addra_q  <= '0;
      din_q    <= '0;
      addrb_q  <= '0;
      for (int s = 0; s < RD_LAT; s++) begin
        vld_q[s]  <= '0;
        fwd_q[s]  <= 1'b0;
        fdat_q[s] <= '0;
      end
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      addra_q   <= addra_d;
      din_q     <= din_d;
      addrb_q   <= addrb_d;
      vld_q[0]  <= rd_gnt;
      fwd_q[0]  <= fwd_s;
      fdat_q[0] <= wr_data_s;
      for (int s = 1; s < RD_LAT; s++) begin
        vld_q[s]  <= vld_q[s-1];
        fwd_q[s]  <= fwd_q[s-1];
        fdat_q[s] <= fdat_q[s-1];
      end
    end
  end

  // Read return: forwarded data wins over RAM output; quiet when nothing returns.
  always_comb begin
    rd_valid = '0;
    rd_data  = '0;
    if (rst || !(|vld_q[RD_LAT-1])) begin
      rd_valid = '0;
      rd_data  = '0;
    end else begin
      rd_valid = vld_q[RD_LAT-1];
      rd_data  = fwd_q[RD_LAT-1] ? fdat_q[RD_LAT-1] : dout;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench: two arbiter instances (RD_LAT=1 and RD_LAT=2), each
// driving a behavioural read-first simple-dual-port RAM model.
module tb_ram_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Instance 1: RD_LAT = 1
  logic [1:0]  wr_req1 = '0, rd_req1 = '0;
  logic [11:0] wr_addr1 = '0, rd_addr1 = '0;
  logic [63:0] wr_data1 = '0;
  logic [1:0]  wr_gnt1, rd_gnt1, rd_valid1;
  logic [31:0] rd_data1, din1, dout1;
  logic [5:0]  addra1, addrb1;
  logic        wea1;
  logic [31:0] mem1 [64];

  // Instance 2: RD_LAT = 2
  logic [1:0]  wr_req2 = '0, rd_req2 = '0;
  logic [11:0] wr_addr2 = '0, rd_addr2 = '0;
  logic [63:0] wr_data2 = '0;
  logic [1:0]  wr_gnt2, rd_gnt2, rd_valid2;
  logic [31:0] rd_data2, din2, dout2, dp2;
  logic [5:0]  addra2, addrb2;
  logic        wea2;
  logic [31:0] mem2 [64];

  int checks   = 0;
  int failures = 0;

  ram_port_arbiter #(.N_REQ(2), .ADDR_W(6), .DATA_W(32), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .wr_req(wr_req1), .wr_addr(wr_addr1), .wr_data(wr_data1), .wr_gnt(wr_gnt1),
    .rd_req(rd_req1), .rd_addr(rd_addr1), .rd_gnt(rd_gnt1),
    .rd_valid(rd_valid1), .rd_data(rd_data1),
    .addra(addra1), .din(din1), .wea(wea1), .addrb(addrb1), .dout(dout1)
  );

  ram_port_arbiter #(.N_REQ(2), .ADDR_W(6), .DATA_W(32), .RD_LAT(2)) dut2 (
    .clk(clk), .rst(rst),
    .wr_req(wr_req2), .wr_addr(wr_addr2), .wr_data(wr_data2), .wr_gnt(wr_gnt2),
    .rd_req(rd_req2), .rd_addr(rd_addr2), .rd_gnt(rd_gnt2),
    .rd_valid(rd_valid2), .rd_data(rd_data2),
    .addra(addra2), .din(din2), .wea(wea2), .addrb(addrb2), .dout(dout2)
  );

  always #5 clk = ~clk;

  // RAM 1: preload on reset (addr 9 = 1, others addr+2), 1-cycle read-first.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem1[i] <= (i == 9) ? 32'h1 : 32'(i) + 32'd2;
      dout1 <= '0;
    end else begin
      if (wea1) mem1[addra1] <= din1;
      dout1 <= mem1[addrb1];
    end
  end

  // RAM 2: preload addr+2 on reset, 2-cycle read-first.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem2[i] <= 32'(i) + 32'd2;
      dp2   <= '0;
      dout2 <= '0;
    end else begin
      if (wea2) mem2[addra2] <= din2;
      dp2   <= mem2[addrb2];
      dout2 <= dp2;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] g [32];
    logic [31:0] snap, v;
    logic [1:0]  exp_g, prev_g;
    logic [5:0]  a1;
    int          tries, w1, maxw;
    bit          granted;

    // ---------------- reset: requests present but grants masked
    rd_req1 = 2'b11;
    wr_req1 = 2'b11;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rd_gnt",   64'(rd_gnt1),   64'h0);
    chk("rst_wr_gnt",   64'(wr_gnt1),   64'h0);
    chk("rst_wea",      64'(wea1),      64'h0);
    chk("rst_rd_valid", 64'(rd_valid1), 64'h0);
    chk("rst_rd_data",  64'(rd_data1),  64'h0);
    chk("rst_addra",    64'(addra1),    64'h0);
    chk("rst_addrb",    64'(addrb1),    64'h0);
    chk("rst_din",      64'(din1),      64'h0);

    // ---------------- single read: req0 reads addr 5 -> 7
    @(negedge clk);
    rst = 1'b0; wr_req1 = 2'b00; rd_req1 = 2'b01; rd_addr1 = {6'd0, 6'd5};
    #1;
    chk("t1_rd_gnt", 64'(rd_gnt1), 64'h1);
    chk("t1_addrb",  64'(addrb1),  64'h5);
    chk("t1_wea",    64'(wea1),    64'h0);
    @(negedge clk);
    rd_req1 = 2'b00;
    #1;
    chk("t1_rd_valid", 64'(rd_valid1), 64'h1);
    chk("t1_rd_data",  64'(rd_data1),  64'h7);

    // ---------------- contention: rd_ptr is 1 after the single read
    prev_g = 2'b00;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rd_req1 = 2'b11; rd_addr1 = {6'd2, 6'd1};
      #1;
      exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
      chk("t2_rd_gnt", 64'(rd_gnt1), 64'(exp_g));
      chk("t2_rd_valid", 64'(rd_valid1), 64'(prev_g));
      if (i > 0) chk("t2_rd_data", 64'(rd_data1), (prev_g == 2'b01) ? 64'h3 : 64'h4);
      prev_g = exp_g;
    end
    @(negedge clk);
    rd_req1 = 2'b00;
    #1;
    chk("t2_last_valid", 64'(rd_valid1), 64'h1);
    chk("t2_last_data",  64'(rd_data1),  64'h3);

    // ---------------- same-cycle write/read to addr 9 (old value 1)
    @(negedge clk);
    wr_req1 = 2'b01; wr_addr1 = {6'd0, 6'd9}; wr_data1 = {32'h0, 32'hDEAD_BEEF};
    rd_req1 = 2'b10; rd_addr1 = {6'd9, 6'd0};
    #1;
    chk("t3_wr_gnt", 64'(wr_gnt1), 64'h1);
    chk("t3_rd_gnt", 64'(rd_gnt1), 64'h2);
    chk("t3_wea",    64'(wea1),    64'h1);
    chk("t3_addra",  64'(addra1),  64'h9);
    chk("t3_din",    64'(din1),    64'hDEAD_BEEF);
    @(negedge clk);
    wr_req1 = 2'b00; rd_req1 = 2'b00; wr_data1 = '0; wr_addr1 = '0;
    #1;
    chk("t3_fwd_valid", 64'(rd_valid1), 64'h2);
    chk("t3_fwd_data",  64'(rd_data1),  64'hDEAD_BEEF);
    chk("t3_wea_idle",  64'(wea1),      64'h0);
    chk("t3_addra_hold", 64'(addra1),   64'h9);
    chk("t3_din_hold",  64'(din1),      64'hDEAD_BEEF);
    @(negedge clk);
    rd_req1 = 2'b01; rd_addr1 = {6'd0, 6'd9};
    #1;
    chk("t3_reread_gnt", 64'(rd_gnt1), 64'h1);
    @(negedge clk);
    rd_req1 = 2'b00;
    #1;
    chk("t3_reread_valid", 64'(rd_valid1), 64'h1);
    chk("t3_reread_data",  64'(rd_data1),  64'hDEAD_BEEF);

    // ---------------- prefix sum: mem[n] = mem[n-1] + mem[n], req1 interferes
    g[0] = 32'd2;
    for (int n = 1; n < 32; n++) begin
      snap = (n == 9) ? 32'hDEAD_BEEF : 32'(n) + 32'd2;
      g[n] = g[n-1] + snap;
    end
    a1 = 6'd40; w1 = 0; maxw = 0;
    for (int n = 1; n < 32; n++) begin
      granted = 1'b0;
      tries = 0;
      while (!granted && tries < 8) begin
        @(negedge clk);
        wr_req1 = 2'b00;
        rd_req1 = 2'b11;
        rd_addr1 = {a1, 6'(n - 1)};
        #1;
        if (rd_gnt1[1]) begin w1 = 0; a1 = a1 + 6'd1; end
        else begin w1++; if (w1 > maxw) maxw = w1; end
        if (rd_gnt1[0]) granted = 1'b1;
        tries++;
      end
      if (!granted) chk("t4_rd_grant_timeout", 64'h0, 64'h1);
      @(negedge clk);
      chk("t4_rd_valid", 64'(rd_valid1), 64'h1);
      v = rd_data1;
      rd_req1 = 2'b10; rd_addr1 = {a1, 6'd0};
      wr_req1 = 2'b01; wr_addr1 = {6'd0, 6'(n)};
      wr_data1 = {32'h0, v + ((n == 9) ? 32'hDEAD_BEEF : 32'(n) + 32'd2)};
      #1;
      chk("t4_wr_gnt", 64'(wr_gnt1), 64'h1);
      if (rd_gnt1[1]) begin w1 = 0; a1 = a1 + 6'd1; end
      else begin w1++; if (w1 > maxw) maxw = w1; end
    end
    @(negedge clk);
    wr_req1 = 2'b00; rd_req1 = 2'b00;
    @(negedge clk);
    for (int n = 0; n < 32; n++) chk($sformatf("t4_mem[%0d]", n), 64'(mem1[n]), 64'(g[n]));
    chk("t4_req1_starve_le2", 64'(maxw <= 2), 64'h1);

    // ---------------- reset mid-operation (pointers moved to 1 first)
    @(negedge clk);
    rd_req1 = 2'b01; rd_addr1 = {6'd0, 6'd3};
    wr_req1 = 2'b01; wr_addr1 = {6'd0, 6'd40}; wr_data1 = {32'h0, 32'h55};
    #1;
    chk("t5_pre_rd_gnt", 64'(rd_gnt1), 64'h1);
    chk("t5_pre_wr_gnt", 64'(wr_gnt1), 64'h1);
    @(negedge clk);
    rst = 1'b1; rd_req1 = 2'b00; wr_req1 = 2'b00;
    #1;
    chk("t5_rst_valid", 64'(rd_valid1), 64'h0);
    chk("t5_rst_data",  64'(rd_data1),  64'h0);
    chk("t5_rst_wea",   64'(wea1),      64'h0);
    chk("t5_rst_addra", 64'(addra1),    64'h0);
    @(negedge clk);
    #1;
    chk("t5_rst_valid2", 64'(rd_valid1), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    rd_req1 = 2'b11; rd_addr1 = {6'd4, 6'd3};
    wr_req1 = 2'b11; wr_addr1 = {6'd2, 6'd1}; wr_data1 = {32'hB, 32'hA};
    #1;
    chk("t5_post_rd_gnt", 64'(rd_gnt1), 64'h1);
    chk("t5_post_wr_gnt", 64'(wr_gnt1), 64'h1);
    chk("t5_post_addra",  64'(addra1),  64'h1);
    chk("t5_post_din",    64'(din1),    64'hA);
    @(negedge clk);
    rd_req1 = 2'b10; wr_req1 = 2'b10;
    #1;
    chk("t5_r0_valid", 64'(rd_valid1), 64'h1);
    chk("t5_r0_data",  64'(rd_data1),  64'h5);
    chk("t5_r1_gnt",   64'(rd_gnt1),   64'h2);
    chk("t5_w1_gnt",   64'(wr_gnt1),   64'h2);
    chk("t5_w1_addra", 64'(addra1),    64'h2);
    @(negedge clk);
    rd_req1 = 2'b00; wr_req1 = 2'b00;
    #1;
    chk("t5_r1_valid", 64'(rd_valid1), 64'h2);
    chk("t5_r1_data",  64'(rd_data1),  64'h6);

    // ---------------- RD_LAT = 2: stream reads 0..7; write addr 2 after its read
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      if (k < 8) begin rd_req2 = 2'b01; rd_addr2 = {6'd0, 6'(k)}; end
      else begin rd_req2 = 2'b00; end
      if (k == 3) begin
        wr_req2 = 2'b10; wr_addr2 = {6'd2, 6'd0}; wr_data2 = {32'h0000_FFFF, 32'h0};
      end else begin
        wr_req2 = 2'b00;
      end
      #1;
      if (k < 8) chk("t6_rd_gnt", 64'(rd_gnt2), 64'h1);
      if (k == 3) chk("t6_wr_gnt", 64'(wr_gnt2), 64'h2);
      if (k >= 2 && k < 10) begin
        chk($sformatf("t6_valid_k%0d", k), 64'(rd_valid2), 64'h1);
        chk($sformatf("t6_data_k%0d", k),  64'(rd_data2),  64'(k));
      end else begin
        chk($sformatf("t6_novalid_k%0d", k), 64'(rd_valid2), 64'h0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
